// File: rtl/serial_add_ctrl_if.sv
// Handshake and result bundle between the serial adder controller and its
// surrounding datapath. The master requests additions; the slave performs them.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell adds two WIDTH-bit
// operands LSB first, one bit per clock. The result registers update only
// on the completion edge, so the datapath always sees a stable value.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   a_sr_q,    a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,    b_sr_d;
  logic [WIDTH-1:0]   res_sr_q,  res_sr_d;
  logic               carry_q,   carry_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   sum_q,     sum_d;
  logic               c_out_q,   c_out_d;
  logic               ovf_q,     ovf_d;
  logic               done_q,    done_d;

  // The single full-adder cell working on the current LSBs and carry.
  logic cell_s;
  logic cell_co;
  logic [WIDTH-1:0] res_shifted;

  // Full-adder cell and the result register as it looks after this bit.
  always_comb begin
    cell_s      = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    cell_co     = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    res_shifted = {cell_s, res_sr_q[WIDTH-1:1]};
  end

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_sr_d = res_shifted;
        carry_d  = cell_co;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB during this final cycle.
          sum_d   = res_shifted;
          c_out_d = cell_co;
          ovf_d   = carry_q ^ cell_co;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge
    // values; blocking ones here would create order-dependent races.
    if (rst) begin
      state_q  <= IDLE;
      // NOTE: the shift registers are overwritten before use, but they are
      // cleared anyway so a reset leaves no stale operand bits behind.
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Registered outputs to the datapath.
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;

endmodule
